// File: rtl/crc_mem_pkg.sv
// rtl/crc_mem_pkg.sv - shared state enum and CRC/burst helper functions for the CRC-protected memory
package crc_mem_pkg;

    typedef enum logic [2:0] {
        S_IDLE,
        S_ENC,
        S_WR,
        S_RD,
        S_DEC,
        S_DONE
    } state_e;

    // Codeword width: payload followed by its CRC.
    function automatic int cw_of(input int data_w, input int crc_w);
        return data_w + crc_w;
    endfunction

    // One MSB-first LFSR step; only the low crc_w bits are meaningful.
    function automatic logic [31:0] crc_step(input logic [31:0] crc, input logic bit_in,
                                             input logic [31:0] poly, input int crc_w);
        logic [31:0] mask;
        logic        fb;
        mask = (32'h1 << crc_w) - 32'h1;
        fb   = (((crc >> (crc_w - 1)) & 32'h1) != 32'h0) ^ bit_in;
        return ((crc << 1) & mask) ^ (fb ? (poly & mask) : 32'h0);
    endfunction

    // Bits lsb..lsb+len_m1 set, clipped at cw (no wrap-around).
    function automatic logic [63:0] burst_mask(input int lsb, input int len_m1, input int cw);
        logic [63:0] m;
        m = '0;
        for (int i = 0; i < 64; i++) begin
            if (i >= lsb && i <= lsb + len_m1 && i < cw) begin
                m = m | (64'h1 << i);
            end
        end
        return m;
    endfunction

endpackage

// File: rtl/crc_protected_memory_param_lfsr.sv
// rtl/crc_protected_memory_param_lfsr.sv - bit-serial CRC LFSR (crc_lfsr_serial), MSB first, init 0
module crc_lfsr_serial
    import crc_mem_pkg::*;
#(
    parameter int               CRC_W = 4,
    parameter logic [CRC_W-1:0] POLY  = 4'h3
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             clear,
    input  logic             shift_en,
    input  logic             bit_in,
    output logic [CRC_W-1:0] crc_out
);

    logic [CRC_W-1:0] crc_q;
    logic [CRC_W-1:0] crc_d;

    // Next remainder: clear wins over shifting.
    always_comb begin
        crc_d = crc_q;
        if (clear) begin
            crc_d = '0;
        end else if (shift_en) begin
            crc_d = CRC_W'(crc_step(32'(crc_q), bit_in, 32'(POLY), CRC_W));
        end
    end

    // Remainder register.
    always_ff @(posedge clk) begin
        if (!rst) begin
            crc_q <= '0;
        end else begin
            crc_q <= crc_d;
        end
    end

    assign crc_out = crc_q;

endmodule

// File: rtl/crc_protected_memory_param.sv
// rtl/crc_protected_memory_param.sv - CRC-protected RAM with serial encode/check; injector under CRC_FAULT_INJECT_EN
module crc_protected_memory_param
    import crc_mem_pkg::*;
#(
    parameter int               DATA_W    = 8,
    parameter int               CRC_W     = 4,
    parameter logic [CRC_W-1:0] POLY      = 4'h3,
    parameter int               DEPTH     = 16,
    parameter int               MAX_BURST = 4,
    parameter int               ERR_CNT_W = 8,
    localparam int              ADDR_W    = $clog2(DEPTH),
    localparam int              CW        = cw_of(DATA_W, CRC_W),
    localparam int              FA_W      = $clog2(CW),
    localparam int              BL_W      = $clog2(MAX_BURST)
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 write,
    input  logic                 read,
    input  logic [ADDR_W-1:0]    addr_in,
    input  logic [DATA_W-1:0]    data_in,
    input  logic                 fault_enable,
    input  logic [FA_W-1:0]      fault_addr,
    input  logic [BL_W-1:0]      burst_len,
    output logic                 write_busy,
    output logic                 read_busy,
    output logic                 data_valid,
    output logic                 error_detected,
    output logic [DATA_W-1:0]    data_out,
    output logic [ERR_CNT_W-1:0] err_count
);

    localparam int CNT_W = $clog2(CW + 1);

    state_e               state_q, state_d;
    logic [CNT_W-1:0]     cnt_q, cnt_d;
    logic [ADDR_W-1:0]    addr_q, addr_d;
    logic [DATA_W-1:0]    data_q, data_d;
    logic [CW-1:0]        cw_q, cw_d;
    logic [DATA_W-1:0]    dout_q, dout_d;
    logic                 err_q, err_d;
    logic [ERR_CNT_W-1:0] err_cnt_q, err_cnt_d;

    logic                 enc_clear, enc_shift, dec_clear, dec_shift;
    logic                 ram_we;
    logic [ADDR_W-1:0]    ram_raddr;
    logic [CW-1:0]        ram_rdata_q;
    logic [CW-1:0]        cw_inj;
    logic [CW-1:0]        cw_rot;
    logic [CRC_W-1:0]     enc_crc, dec_crc;
    logic [CW-1:0]        mem [DEPTH];

`ifdef CRC_FAULT_INJECT_EN
    // Burst injector: invert the selected bits of the word read from RAM.
    assign cw_inj = fault_enable
                  ? (ram_rdata_q ^ CW'(burst_mask(int'(fault_addr), int'(burst_len), CW)))
                  : ram_rdata_q;
`else
    // No injector: codeword passes through untouched, fault ports are inert.
    assign cw_inj = ram_rdata_q;
    wire unused_fault = &{1'b0, fault_enable, fault_addr, burst_len};
`endif

    // Both the payload and the captured codeword rotate rather than shift, so
    // after a full pass they are back in their original order.
    assign cw_rot = {cw_q[CW-2:0], cw_q[CW-1]};

    crc_lfsr_serial #(.CRC_W(CRC_W), .POLY(POLY)) u_enc (
        .clk      (clk),
        .rst      (rst),
        .clear    (enc_clear),
        .shift_en (enc_shift),
        .bit_in   (data_q[DATA_W-1]),
        .crc_out  (enc_crc)
    );

    crc_lfsr_serial #(.CRC_W(CRC_W), .POLY(POLY)) u_dec (
        .clk      (clk),
        .rst      (rst),
        .clear    (dec_clear),
        .shift_en (dec_shift),
        .bit_in   (cw_q[CW-1]),
        .crc_out  (dec_crc)
    );

    // Next-state and datapath control for the write/read sequencer.
    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        addr_d    = addr_q;
        data_d    = data_q;
        cw_d      = cw_q;
        dout_d    = dout_q;
        err_d     = err_q;
        err_cnt_d = err_cnt_q;
        enc_clear = 1'b0;
        enc_shift = 1'b0;
        dec_clear = 1'b0;
        dec_shift = 1'b0;
        ram_we    = 1'b0;
        ram_raddr = addr_q;
        unique case (state_q)
            S_IDLE: begin
                ram_raddr = addr_in;
                if (write) begin
                    state_d   = S_ENC;
                    addr_d    = addr_in;
                    data_d    = data_in;
                    cnt_d     = '0;
                    enc_clear = 1'b1;
                end else if (read) begin
                    state_d   = S_RD;
                    addr_d    = addr_in;
                end
            end
            S_ENC: begin
                enc_shift = 1'b1;
                data_d    = {data_q[DATA_W-2:0], data_q[DATA_W-1]};
                cnt_d     = cnt_q + 1'b1;
                if (cnt_q == CNT_W'(DATA_W - 1)) begin
                    state_d = S_WR;
                    cnt_d   = '0;
                end
            end
            S_WR: begin
                ram_we  = rst;
                state_d = S_IDLE;
            end
            S_RD: begin
                cw_d      = cw_inj;
                cnt_d     = '0;
                dec_clear = 1'b1;
                state_d   = S_DEC;
            end
            S_DEC: begin
                dec_shift = 1'b1;
                cw_d      = cw_rot;
                cnt_d     = cnt_q + 1'b1;
                if (cnt_q == CNT_W'(CW - 1)) begin
                    state_d = S_DONE;
                    cnt_d   = '0;
                    dout_d  = cw_rot[CW-1:CRC_W];
                    err_d   = CRC_W'(crc_step(32'(dec_crc), cw_q[CW-1], 32'(POLY), CRC_W)) != '0;
                end
            end
            S_DONE: begin
                if (err_q && err_cnt_q != '1) begin
                    err_cnt_d = err_cnt_q + 1'b1;
                end
                state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    // Sequencer and output registers.
    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q   <= S_IDLE;
            cnt_q     <= '0;
            addr_q    <= '0;
            data_q    <= '0;
            cw_q      <= '0;
            dout_q    <= '0;
            err_q     <= 1'b0;
            err_cnt_q <= '0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            addr_q    <= addr_d;
            data_q    <= data_d;
            cw_q      <= cw_d;
            dout_q    <= dout_d;
            err_q     <= err_d;
            err_cnt_q <= err_cnt_d;
        end
    end

    // Codeword RAM: synchronous write and registered read, contents not reset.
    always_ff @(posedge clk) begin
        if (ram_we) begin
            mem[addr_q] <= {data_q, enc_crc};
        end
        ram_rdata_q <= mem[ram_raddr];
    end

    assign write_busy     = (state_q == S_ENC) || (state_q == S_WR);
    assign read_busy      = (state_q == S_RD) || (state_q == S_DEC) || (state_q == S_DONE);
    assign data_valid     = (state_q == S_DONE);
    assign error_detected = err_q;
    assign data_out       = dout_q;
    assign err_count      = err_cnt_q;

endmodule

// File: tb/tb_crc_protected_memory_param.sv
// tb/tb_crc_protected_memory_param.sv - directed self-checking bench for crc_protected_memory_param
module tb_crc_protected_memory_param;

`ifdef CRC_FAULT_INJECT_EN
    localparam bit INJ = 1'b1;
`else
    localparam bit INJ = 1'b0;
`endif

    logic       clk = 1'b0;
    logic       rst;
    logic       write;
    logic       read;
    logic [3:0] addr_in;
    logic [7:0] data_in;
    logic       fault_enable;
    logic [3:0] fault_addr;
    logic [1:0] burst_len;
    logic       write_busy;
    logic       read_busy;
    logic       data_valid;
    logic       error_detected;
    logic [7:0] data_out;
    logic [1:0] err_count;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    crc_protected_memory_param #(.ERR_CNT_W(2)) dut (
        .clk            (clk),
        .rst            (rst),
        .write          (write),
        .read           (read),
        .addr_in        (addr_in),
        .data_in        (data_in),
        .fault_enable   (fault_enable),
        .fault_addr     (fault_addr),
        .burst_len      (burst_len),
        .write_busy     (write_busy),
        .read_busy      (read_busy),
        .data_valid     (data_valid),
        .error_detected (error_detected),
        .data_out       (data_out),
        .err_count      (err_count)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_write(input logic [3:0] a, input logic [7:0] d, output int busy_cycles);
        write   = 1'b1;
        addr_in = a;
        data_in = d;
        tick();
        write = 1'b0;
        busy_cycles = 0;
        while (write_busy && busy_cycles < 50) begin
            busy_cycles++;
            tick();
        end
    endtask

    task automatic do_read(input logic [3:0] a, input logic fe, input logic [3:0] fa,
                           input logic [1:0] bl, output int lat, output logic [7:0] dout,
                           output logic derr);
        read         = 1'b1;
        addr_in      = a;
        fault_enable = fe;
        fault_addr   = fa;
        burst_len    = bl;
        tick();
        read = 1'b0;
        lat  = 1;
        while (!data_valid && lat < 40) begin
            tick();
            lat++;
        end
        dout = data_out;
        derr = error_detected;
        tick();
        fault_enable = 1'b0;
        fault_addr   = '0;
        burst_len    = '0;
    endtask

    task automatic test_reset();
        rst = 1'b0;
        repeat (3) tick();
        total++;
        if ({write_busy, read_busy, data_valid, error_detected} !== 4'b0000) begin
            bad++;
            $display("FAIL reset_flags got=%b want=0000", {write_busy, read_busy, data_valid, error_detected});
        end
        total++;
        if (data_out !== 8'h00) begin
            bad++;
            $display("FAIL reset_data got=%h want=00", data_out);
        end
        total++;
        if (err_count !== 2'b00) begin
            bad++;
            $display("FAIL reset_errcnt got=%0d want=0", err_count);
        end
        rst = 1'b1;
        tick();
    endtask

    task automatic test_write_read();
        int         busy;
        int         lat;
        logic [7:0] d;
        logic       e;
        logic [3:0] addrs [3] = '{4'd0, 4'd15, 4'd5};
        logic [7:0] datas [3] = '{8'h00, 8'hFF, 8'h3C};
        do_write(4'd3, 8'hA5, busy);
        total++;
        if (busy !== 9) begin
            bad++;
            $display("FAIL write_busy_len got=%0d want=9", busy);
        end
        total++;
        if (dut.mem[3] !== 12'hA5B) begin
            bad++;
            $display("FAIL stored_word got=%h want=a5b", dut.mem[3]);
        end
        do_read(4'd3, 1'b0, 4'd0, 2'd0, lat, d, e);
        total++;
        if (lat !== 14) begin
            bad++;
            $display("FAIL read_latency got=%0d want=14", lat);
        end
        total++;
        if (d !== 8'hA5 || e !== 1'b0) begin
            bad++;
            $display("FAIL read_a5 got=%h/%b want=a5/0", d, e);
        end
        for (int i = 0; i < 3; i++) begin
            do_write(addrs[i], datas[i], busy);
        end
        for (int i = 0; i < 3; i++) begin
            do_read(addrs[i], 1'b0, 4'd0, 2'd0, lat, d, e);
            total++;
            if (d !== datas[i] || e !== 1'b0 || lat !== 14) begin
                bad++;
                $display("FAIL read_pattern%0d got=%h/%b/%0d want=%h/0/14", i, d, e, lat, datas[i]);
            end
        end
        total++;
        if (err_count !== 2'd0) begin
            bad++;
            $display("FAIL clean_errcnt got=%0d want=0", err_count);
        end
    endtask

    task automatic test_fault_burst();
        int         lat;
        logic [7:0] d;
        logic       e;
        do_read(4'd3, 1'b1, 4'd2, 2'd2, lat, d, e);
        total++;
        if (d !== (INJ ? 8'hA4 : 8'hA5) || e !== INJ) begin
            bad++;
            $display("FAIL burst_2_4 got=%h/%b want=%h/%b", d, e, INJ ? 8'hA4 : 8'hA5, INJ);
        end
        total++;
        if (err_count !== (INJ ? 2'd1 : 2'd0)) begin
            bad++;
            $display("FAIL burst_errcnt1 got=%0d want=%0d", err_count, INJ ? 1 : 0);
        end
        do_read(4'd3, 1'b1, 4'd10, 2'd3, lat, d, e);
        total++;
        if (d !== (INJ ? 8'h65 : 8'hA5) || e !== INJ) begin
            bad++;
            $display("FAIL burst_clip got=%h/%b want=%h/%b", d, e, INJ ? 8'h65 : 8'hA5, INJ);
        end
        total++;
        if (err_count !== (INJ ? 2'd2 : 2'd0)) begin
            bad++;
            $display("FAIL burst_errcnt2 got=%0d want=%0d", err_count, INJ ? 2 : 0);
        end
    endtask

    task automatic test_priority();
        int         dv_seen;
        int         lat;
        logic [7:0] d;
        logic       e;
        dv_seen = 0;
        write   = 1'b1;
        read    = 1'b1;
        addr_in = 4'd7;
        data_in = 8'h5A;
        tick();
        write = 1'b0;
        read  = 1'b0;
        total++;
        if (write_busy !== 1'b1 || read_busy !== 1'b0) begin
            bad++;
            $display("FAIL both_req got=%b%b want=10", write_busy, read_busy);
        end
        for (int i = 0; i < 15; i++) begin
            if (data_valid) dv_seen++;
            tick();
        end
        write   = 1'b1;
        addr_in = 4'd9;
        data_in = 8'hC3;
        tick();
        write = 1'b0;
        tick();
        read    = 1'b1;
        addr_in = 4'd7;
        tick();
        read = 1'b0;
        for (int i = 0; i < 30; i++) begin
            if (data_valid) dv_seen++;
            tick();
        end
        total++;
        if (dv_seen !== 0) begin
            bad++;
            $display("FAIL dropped_read got=%0d want=0", dv_seen);
        end
        do_read(4'd7, 1'b0, 4'd0, 2'd0, lat, d, e);
        total++;
        if (d !== 8'h5A || e !== 1'b0) begin
            bad++;
            $display("FAIL priority_write got=%h/%b want=5a/0", d, e);
        end
        do_read(4'd9, 1'b0, 4'd0, 2'd0, lat, d, e);
        total++;
        if (d !== 8'hC3 || e !== 1'b0) begin
            bad++;
            $display("FAIL busy_write got=%h/%b want=c3/0", d, e);
        end
    endtask

    task automatic test_reset_mid();
        int         lat;
        logic [7:0] d;
        logic       e;
        read    = 1'b1;
        addr_in = 4'd3;
        tick();
        read = 1'b0;
        repeat (4) tick();
        rst = 1'b0;
        tick();
        total++;
        if ({write_busy, read_busy, data_valid, error_detected, data_out, err_count} !== 14'd0) begin
            bad++;
            $display("FAIL reset_in_dec got=%b%b%b%b/%h/%0d want=all zero",
                     write_busy, read_busy, data_valid, error_detected, data_out, err_count);
        end
        rst = 1'b1;
        do_read(4'd3, 1'b0, 4'd0, 2'd0, lat, d, e);
        total++;
        if (d !== 8'hA5 || e !== 1'b0 || lat !== 14) begin
            bad++;
            $display("FAIL after_reset_read got=%h/%b/%0d want=a5/0/14", d, e, lat);
        end
        write   = 1'b1;
        addr_in = 4'd3;
        data_in = 8'hFF;
        tick();
        write = 1'b0;
        repeat (8) tick();
        rst = 1'b0;
        tick();
        rst = 1'b1;
        total++;
        if (write_busy !== 1'b0) begin
            bad++;
            $display("FAIL reset_in_wr got=%b want=0", write_busy);
        end
        do_read(4'd3, 1'b0, 4'd0, 2'd0, lat, d, e);
        total++;
        if (d !== 8'hA5 || e !== 1'b0) begin
            bad++;
            $display("FAIL interrupted_write got=%h/%b want=a5/0", d, e);
        end
    endtask

    task automatic test_saturation();
        int         lat;
        logic [7:0] d;
        logic       e;
        logic [1:0] want;
        for (int k = 1; k <= 5; k++) begin
            do_read(4'd3, 1'b1, 4'd0, 2'd0, lat, d, e);
            want = INJ ? ((k > 3) ? 2'd3 : 2'(k)) : 2'd0;
            total++;
            if (err_count !== want || e !== INJ || d !== 8'hA5) begin
                bad++;
                $display("FAIL saturate%0d got=%0d/%b/%h want=%0d/%b/a5", k, err_count, e, d, want, INJ);
            end
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog expired");
        $fatal(1);
    end

    initial begin
        rst          = 1'b0;
        write        = 1'b0;
        read         = 1'b0;
        addr_in      = '0;
        data_in      = '0;
        fault_enable = 1'b0;
        fault_addr   = '0;
        burst_len    = '0;
        tick();
        test_reset();
        test_write_read();
        test_fault_burst();
        test_priority();
        test_reset_mid();
        test_saturation();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
